// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: bundle of the sequencer's handshake and bus signals.
//   in_*      : instruction handshake and payload (op/dst/src/imm/use_imm)
//   alu_*     : operands/opcode to the external ALU and its result/flags back
//   out_*/err : result handshake and payload
//   rd_*      : debug register-file read port
// Modport slave is the sequencer side; master is the environment side.
interface alu_sequencer_if;
   localparam int unsigned DW = 8;
   localparam int unsigned FW = 3;
   localparam int unsigned OW = 4;
   localparam int unsigned AW = 2;

   logic          in_valid;
   logic          in_ready;
   logic [OW-1:0] in_op;
   logic [AW-1:0] in_dst;
   logic [AW-1:0] in_src;
   logic [DW-1:0] in_imm;
   logic          in_use_imm;

   logic [DW-1:0] alu_a;
   logic [DW-1:0] alu_b;
   logic [OW-1:0] alu_op;
   logic [DW-1:0] alu_r;
   logic [FW-1:0] alu_f;

   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [FW-1:0] out_flags;
   logic          err;

   logic [AW-1:0] rd_sel;
   logic [DW-1:0] rd_data;

   modport slave (
      input  in_valid, in_op, in_dst, in_src, in_imm, in_use_imm,
      output in_ready,
      output alu_a, alu_b, alu_op,
      input  alu_r, alu_f,
      output out_valid, out_data, out_flags, err,
      input  out_ready,
      input  rd_sel,
      output rd_data
   );

   modport master (
      output in_valid, in_op, in_dst, in_src, in_imm, in_use_imm,
      input  in_ready,
      input  alu_a, alu_b, alu_op,
      output alu_r, alu_f,
      input  out_valid, out_data, out_flags, err,
      output out_ready,
      output rd_sel,
      input  rd_data
   );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts one instruction at a time, drives an external
// combinational ALU from a 4x8 register file, writes the result back and
// presents it on a valid/ready result port.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : alu_sequencer_if.slave (instruction, ALU, result and debug read)
// Opcodes with the MSB set are illegal: they never reach the ALU, leave the
// register file and flags alone, and return REG[dst]/FLG with err set.
module alu_sequencer #(
   parameter logic [7:0] REG_INIT = 8'h00
) (
   input logic            clk,
   input logic            rst,
   alu_sequencer_if.slave bus
);
   localparam int unsigned DW   = 8;
   localparam int unsigned FW   = 3;
   localparam int unsigned OW   = 4;
   localparam int unsigned AW   = 2;
   localparam int unsigned NREG = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t        state;
   logic [OW-1:0] op_q;
   logic [AW-1:0] dst_q;
   logic [AW-1:0] src_q;
   logic [DW-1:0] imm_q;
   logic          use_imm_q;
   logic [DW-1:0] regs [NREG];
   logic [FW-1:0] flg;

   logic accept_c;
   logic illegal_c;

   // Ready while idle, or while the pending result is being taken this cycle.
   assign bus.in_ready = (state == IDLE) | ((state == RESP) & bus.out_ready);
   assign accept_c     = bus.in_valid & bus.in_ready;
   assign illegal_c    = op_q[OW-1];

   // Operands always come from the instruction latches.
   assign bus.alu_a   = regs[dst_q];
   assign bus.alu_b   = use_imm_q ? imm_q : regs[src_q];
   assign bus.alu_op  = illegal_c ? OW'(0) : op_q;
   assign bus.rd_data = regs[bus.rd_sel];

   // Sequencer FSM, instruction latches, register file and result registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         op_q      <= '0;
         dst_q     <= '0;
         src_q     <= '0;
         imm_q     <= '0;
         use_imm_q <= 1'b0;
         for (int unsigned i = 0; i < NREG; i++) begin
            regs[i] <= REG_INIT;
         end
         flg           <= '0;
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_flags <= '0;
         bus.err       <= 1'b0;
      end else begin
         if (accept_c) begin
            op_q      <= bus.in_op;
            dst_q     <= bus.in_dst;
            src_q     <= bus.in_src;
            imm_q     <= bus.in_imm;
            use_imm_q <= bus.in_use_imm;
         end
         case (state)
            IDLE: begin
               if (accept_c) begin
                  state <= EXEC;
               end
            end
            EXEC: begin
               state         <= RESP;
               bus.out_valid <= 1'b1;
               if (!illegal_c) begin
                  regs[dst_q]   <= bus.alu_r;
                  flg           <= bus.alu_f;
                  bus.out_data  <= bus.alu_r;
                  bus.out_flags <= bus.alu_f;
                  bus.err       <= 1'b0;
               end else begin
                  bus.out_data  <= regs[dst_q];
                  bus.out_flags <= flg;
                  bus.err       <= 1'b1;
               end
            end
            RESP: begin
               // in_ready is high here, so accept_c is just in_valid.
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  state         <= accept_c ? EXEC : IDLE;
               end
            end
            default: begin
               state         <= IDLE;
               bus.out_valid <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed bench for alu_sequencer with a transaction-level
// reference model and a per-cycle compare process.
`timescale 1ns/1ps
module tb_alu_sequencer;
   localparam logic [7:0] RI = 8'hA5;

   logic clk;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   alu_sequencer_if bus ();

   alu_sequencer #(.REG_INIT(RI)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference ALU: returns {result, sign, carry, all-ones}.
   function automatic logic [10:0] alu_fn(input logic [3:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
      logic [8:0] w;
      logic [7:0] r;
      logic       c;
      w = 9'd0;
      c = 1'b0;
      case (op)
         4'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8]; end
         4'd1: begin r = a - b; c = (a < b); end
         4'd2: r = a & b;
         4'd3: r = a | b;
         4'd4: r = ~a;
         4'd5: begin r = {a[6:0], 1'b0}; c = a[7]; end
         4'd6: r = a ^ b;
         default: r = b;
      endcase
      return {r, r[7], c, &r};
   endfunction

   // Downstream ALU attached to the DUT.
   always_comb begin
      {bus.alu_r, bus.alu_f} = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model (transaction level) ----------------
   logic [7:0] m_reg [4];
   logic [2:0] m_flg;
   logic       m_busy;      // instruction accepted, result not yet produced
   logic       m_have;      // result produced, not yet taken
   logic [7:0] m_data;
   logic [2:0] m_flags;
   logic       m_err;
   logic [3:0] m_op;
   logic [1:0] m_dst;
   logic [1:0] m_src;
   logic [7:0] m_imm;
   logic       m_use;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 4; i++) m_reg[i] <= RI;
         m_flg   <= 3'd0;
         m_busy  <= 1'b0;
         m_have  <= 1'b0;
         m_data  <= 8'd0;
         m_flags <= 3'd0;
         m_err   <= 1'b0;
         m_op    <= 4'd0;
         m_dst   <= 2'd0;
         m_src   <= 2'd0;
         m_imm   <= 8'd0;
         m_use   <= 1'b0;
      end else begin : upd
         logic        acc;
         logic [7:0]  b;
         logic [10:0] rf;
         acc = bus.in_valid && !m_busy && (!m_have || bus.out_ready);
         b   = m_use ? m_imm : m_reg[m_src];
         rf  = alu_fn(m_op, m_reg[m_dst], b);
         m_busy <= acc;
         if (m_busy) begin
            m_have <= 1'b1;
            if (m_op < 4'd8) begin
               m_reg[m_dst] <= rf[10:3];
               m_flg        <= rf[2:0];
               m_data       <= rf[10:3];
               m_flags      <= rf[2:0];
               m_err        <= 1'b0;
            end else begin
               m_data  <= m_reg[m_dst];
               m_flags <= m_flg;
               m_err   <= 1'b1;
            end
         end else if (m_have && bus.out_ready) begin
            m_have <= 1'b0;
         end
         if (acc) begin
            m_op  <= bus.in_op;
            m_dst <= bus.in_dst;
            m_src <= bus.in_src;
            m_imm <= bus.in_imm;
            m_use <= bus.in_use_imm;
         end
      end
   end

   // Per-cycle compare against the model, sampled mid-cycle.
   always @(negedge clk) begin
      chk("in_ready",  32'(bus.in_ready),  32'(!m_busy && (!m_have || bus.out_ready)));
      chk("out_valid", 32'(bus.out_valid), 32'(m_have));
      chk("out_data",  32'(bus.out_data),  32'(m_data));
      chk("out_flags", 32'(bus.out_flags), 32'(m_flags));
      chk("err",       32'(bus.err),       32'(m_err));
      chk("alu_op",    32'(bus.alu_op),    32'((m_op < 4'd8) ? m_op : 4'd0));
      chk("alu_a",     32'(bus.alu_a),     32'(m_reg[m_dst]));
      chk("alu_b",     32'(bus.alu_b),     32'(m_use ? m_imm : m_reg[m_src]));
      chk("rd_data",   32'(bus.rd_data),   32'(m_reg[bus.rd_sel]));
   end

   // ---------------- directed stimulus ----------------
   task automatic send(input logic [3:0] op, input logic [1:0] dst, input logic [1:0] src,
                       input logic [7:0] imm, input logic use_imm);
      logic acc;
      acc            = 1'b0;
      bus.in_valid   = 1'b1;
      bus.in_op      = op;
      bus.in_dst     = dst;
      bus.in_src     = src;
      bus.in_imm     = imm;
      bus.in_use_imm = use_imm;
      bus.rd_sel     = dst;
      for (int i = 0; i < 20 && !acc; i++) begin
         @(negedge clk);
         acc = bus.in_ready;
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      if (!acc) chk("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_resp(input logic [7:0] d, input logic [2:0] f, input logic e,
                            input string nm);
      int   n;
      logic seen;
      n    = 0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         n++;
         seen = bus.out_valid;
      end
      chk({nm, "_latency"}, 32'(n), 32'd2);
      chk({nm, "_data"},    32'(bus.out_data),  32'(d));
      chk({nm, "_flags"},   32'(bus.out_flags), 32'(f));
      chk({nm, "_err"},     32'(bus.err),       32'(e));
      @(posedge clk);
      #1;
   endtask

   task automatic rd_check(input logic [1:0] sel, input logic [7:0] exp, input string nm);
      bus.rd_sel = sel;
      @(negedge clk);
      chk(nm, 32'(bus.rd_data), 32'(exp));
      chk({nm, "_model"}, 32'(m_reg[sel]), 32'(exp));
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.in_valid   = 1'b0;
      bus.in_op      = 4'd0;
      bus.in_dst     = 2'd0;
      bus.in_src     = 2'd0;
      bus.in_imm     = 8'd0;
      bus.in_use_imm = 1'b0;
      bus.out_ready  = 1'b1;
      bus.rd_sel     = 2'd0;
      rst = 1'b1;
      #1 rst = 1'b0;

      // Reset state.
      @(negedge clk);
      chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_alu_a",     32'(bus.alu_a),     32'(RI));
      chk("rst_alu_b",     32'(bus.alu_b),     32'(RI));
      chk("rst_alu_op",    32'(bus.alu_op),    32'd0);
      @(posedge clk);
      #1 rst = 1'b1;
      for (int s = 0; s < 4; s++) rd_check(2'(s), RI, "rst_reg");

      // ADD with sign result.
      send(4'd7, 2'd0, 2'd0, 8'h7F, 1'b1); wait_resp(8'h7F, 3'b000, 1'b0, "ld0");
      send(4'd0, 2'd0, 2'd0, 8'h01, 1'b1); wait_resp(8'h80, 3'b100, 1'b0, "add");
      rd_check(2'd0, 8'h80, "add_reg0");

      // SUB with borrow; then illegal opcodes that must preserve REG/FLG.
      send(4'd7, 2'd2, 2'd0, 8'h5A, 1'b1); wait_resp(8'h5A, 3'b000, 1'b0, "ld2");
      send(4'd7, 2'd1, 2'd0, 8'h00, 1'b1); wait_resp(8'h00, 3'b000, 1'b0, "ld1");
      send(4'd1, 2'd1, 2'd0, 8'h01, 1'b1); wait_resp(8'hFF, 3'b111, 1'b0, "sub");
      rd_check(2'd1, 8'hFF, "sub_reg1");
      send(4'd9, 2'd2, 2'd0, 8'h33, 1'b1); wait_resp(8'h5A, 3'b111, 1'b1, "ill9");
      rd_check(2'd2, 8'h5A, "ill_reg2");
      send(4'd15, 2'd1, 2'd2, 8'h00, 1'b0); wait_resp(8'hFF, 3'b111, 1'b1, "ill15");

      // Backpressure, then back-to-back accept while the result is taken.
      bus.out_ready = 1'b0;
      send(4'd0, 2'd0, 2'd0, 8'h01, 1'b1); wait_resp(8'h81, 3'b100, 1'b0, "bp");
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_valid",    32'(bus.out_valid), 32'd1);
         chk("bp_data",     32'(bus.out_data),  32'h81);
         chk("bp_in_ready", 32'(bus.in_ready),  32'd0);
      end
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      send(4'd2, 2'd0, 2'd0, 8'h0F, 1'b1); wait_resp(8'h01, 3'b000, 1'b0, "b2b");

      // Reset while XOR is in EXEC: no write-back, no response.
      send(4'd7, 2'd3, 2'd0, 8'h3C, 1'b1); wait_resp(8'h3C, 3'b000, 1'b0, "ld3");
      send(4'd6, 2'd3, 2'd0, 8'hFF, 1'b1);
      rst = 1'b0;
      #2;
      chk("rstx_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rstx_in_ready",  32'(bus.in_ready),  32'd1);
      @(posedge clk);
      #1 rst = 1'b1;
      rd_check(2'd3, RI, "rstx_reg3");
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("rstx_no_resp", 32'(bus.out_valid), 32'd0);
      end
      @(posedge clk);
      #1;

      // SRC == DST reads the pre-write value; then a two-register add.
      send(4'd7, 2'd0, 2'd0, 8'h03, 1'b1); wait_resp(8'h03, 3'b000, 1'b0, "ld0b");
      send(4'd0, 2'd0, 2'd0, 8'h00, 1'b0); wait_resp(8'h06, 3'b000, 1'b0, "same");
      send(4'd0, 2'd1, 2'd0, 8'h00, 1'b0); wait_resp(8'hAB, 3'b100, 1'b0, "add_rr");
      send(4'd5, 2'd1, 2'd0, 8'h00, 1'b1); wait_resp(8'h56, 3'b010, 1'b0, "shl");

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
